gray_counter: RTL and testbench
===============================

# gray_counter

Free-running, parameterizable Gray-code counter. After reset it advances one code per clock, and adjacent codes differ in exactly one bit. It sits in the counters library as a glitch-safe source for multi-bit values sampled by other logic, such as pointers or status indices. It also exposes the equivalent binary count, a terminal-code flag and a self-check flag.

## Interface
- WIDTH, default 4: counter width in bits, legal range 2..32.
- clk  input  1  rising-edge clock; the only clock in the block.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- gray  output  WIDTH  registered Gray code of the current count.
- bin  output  WIDTH  registered binary count; gray always equals bin ^ (bin >> 1).
- wrap  output  1  high while gray holds the terminal code (MSB set, all other bits 0).
- err  output  1  sticky flag; set if the internal checker sees an illegal Gray transition.

Only clk, rst and gray are mandatory connections. bin, wrap and err may be left unconnected.

## Operation
- State held in the block:
  - binary register B[WIDTH-1:0];
  - Gray register G[WIDTH-1:0];
  - previous-Gray register P;
  - sticky err flag.
- Reset (rst=1 at a rising clk edge):
  - B, G and P are cleared to 0;
  - err is cleared to 0;
  - reset has priority over counting on every edge.
- Count (rst=0 at a rising clk edge):
  - B ← B + 1, modulo 2^WIDTH;
  - G ← (B+1) ^ ((B+1) >> 1), computed from the next binary value so that G stays in lockstep with B;
  - P ← G.
- Sequence for WIDTH=4, starting at reset: 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then back to 0000.
- Wrap-around:
  - terminal binary value 2^WIDTH−1 maps to Gray 100…0;
  - the next code is 000…0, which is also a single-bit change;
  - there is no stall or saturation at the terminal value.
- wrap: combinational decode of G == {1'b1, {WIDTH-1{1'b0}}}. High for exactly one cycle in every 2^WIDTH.
- Checker:
  - on each counting edge after the first post-reset advance, compute popcount(G ^ P);
  - if it is not exactly 1, set err;
  - err stays set until the next reset.
- Arithmetic:
  - all values are unsigned, WIDTH bits;
  - the carry out of the increment is discarded.

## Timing
- Outputs gray, bin and err are registered and change only on rising clk edges. wrap is combinational from G and has no further register delay.
- Reset timing:
  - the first rising edge with rst=1 forces gray=0, bin=0, wrap=0, err=0;
  - the outputs hold these values on every edge while rst stays high.
- Latency after reset release:
  - the first rising edge with rst=0 produces gray=0001;
  - each later edge advances exactly one code.
- Reset asserted mid-count: the next rising edge returns all outputs to 0, whatever the current code, including the terminal code.
- Outputs before the first reset edge are undefined (X). The bench must apply reset first.
- Period of gray and bin: 2^WIDTH clocks.

## Test plan
- Reset: hold rst=1 for 2 edges.
  - Required: gray=0000, bin=0000, wrap=0, err=0.
  - Release rst 2 ns after an edge; the next edge must give gray=0001, and the edge after that gray=0011.
- Full cycle, WIDTH=4: after reset, run 16 edges.
  - Required: gray follows 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, 0000.
  - bin must equal 1..15 then 0 on the same edges.
  - err must stay 0.
- Wrap flag:
  - wrap=1 exactly while gray=1000 (bin=15);
  - 0 otherwise;
  - it recurs every 16 clocks over a 200 ns run with a 10 ns clock.
- Single-bit property: over 40 consecutive edges, popcount(gray ^ previous gray) == 1 on every edge, including the 1000→0000 transition.
- Mid-run reset: assert rst for one edge while gray=0110.
  - Required: the next edge gives gray=0000 and bin=0000.
  - Counting resumes at 0001 on the following edge.
- Parameter: WIDTH=3.
  - Required sequence: 001, 011, 010, 110, 111, 101, 100, 000.
  - wrap high only at 100.

Source files
------------

// File: rtl/gray_counter.sv
// Free-running Gray-code counter with a lockstep binary count, a terminal-code
// decode and a sticky flag that latches any multi-bit Gray transition.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] TERMINAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Binary to reflected Gray conversion.
    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Number of set bits; 6 bits covers WIDTH up to 32.
    function automatic logic [5:0] popcount(input logic [WIDTH-1:0] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic [WIDTH-1:0] prev_q,  prev_d;
    logic             armed_q, armed_d;
    logic             err_q,   err_d;
    logic             step_bad_s;

    // Next-state: advance binary, derive Gray from the new binary value, and
    // judge the transition that produced the current Gray code.
    always_comb begin
        bin_d      = bin_q + ONE;
        gray_d     = bin2gray(bin_d);
        prev_d     = gray_q;
        armed_d    = 1'b1;
        step_bad_s = 1'b0;
        if (armed_q) begin
            step_bad_s = (popcount(gray_q ^ prev_q) != 6'd1);
        end else begin
            step_bad_s = 1'b0;
        end
        err_d = err_q | step_bad_s;
    end

    // State registers; synchronous reset takes priority over counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q   <= '0;
            gray_q  <= '0;
            prev_q  <= '0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
            err_q   <= err_d;
        end
    end

    assign gray = gray_q;
    assign bin  = bin_q;
    assign err  = err_q;
    // wrap is a direct decode of the Gray register, no extra cycle.
    assign wrap = (gray_q == TERMINAL);

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter at WIDTH=4 and WIDTH=3 against hand-written
// Gray tables.
module tb_gray_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gray4, bin4;
    logic       wrap4, err4;
    logic [2:0] gray3, bin3;
    logic       wrap3, err3;

    int compared   = 0;
    int mismatched = 0;
    int b4 = 0;
    int b3 = 0;
    logic [3:0] prev4 = 4'b0000;

    logic [3:0] g4_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [2:0] g3_tab [8]  = '{3'b000, 3'b001, 3'b011, 3'b010,
                                3'b110, 3'b111, 3'b101, 3'b100};

    gray_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .gray(gray4), .bin(bin4), .wrap(wrap4), .err(err4)
    );

    gray_counter #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .gray(gray3), .bin(bin3), .wrap(wrap3), .err(err3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
            $error("%s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gray4"}, 32'(gray4), 32'd0);
        chk({tag, "_bin4"},  32'(bin4),  32'd0);
        chk({tag, "_wrap4"}, 32'(wrap4), 32'd0);
        chk({tag, "_err4"},  32'(err4),  32'd0);
        chk({tag, "_gray3"}, 32'(gray3), 32'd0);
        chk({tag, "_bin3"},  32'(bin3),  32'd0);
        chk({tag, "_err3"},  32'(err3),  32'd0);
    endtask

    task automatic step_check();
        tick();
        b4 = (b4 + 1) % 16;
        b3 = (b3 + 1) % 8;
        chk("gray4",   32'(gray4), 32'(g4_tab[b4]));
        chk("bin4",    32'(bin4),  32'(b4));
        chk("wrap4",   32'(wrap4), (b4 == 15) ? 32'd1 : 32'd0);
        chk("err4",    32'(err4),  32'd0);
        chk("onebit4", 32'($countones(gray4 ^ prev4)), 32'd1);
        prev4 = gray4;
        chk("gray3",   32'(gray3), 32'(g3_tab[b3]));
        chk("bin3",    32'(bin3),  32'(b3));
        chk("wrap3",   32'(wrap3), (b3 == 7) ? 32'd1 : 32'd0);
        chk("err3",    32'(err3),  32'd0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check_zero("reset");

        // Release 2 ns after an edge; first edge gives 0001, then 0011.
        rst   = 1'b0;
        b4    = 0;
        b3    = 0;
        prev4 = 4'b0000;
        for (int i = 0; i < 16; i++) step_check();

        // 40 more edges: single-bit property and wrap recurrence.
        for (int i = 0; i < 40; i++) step_check();

        // 56 edges so far leaves bin4 at 8; 12 more lands on 0110.
        for (int i = 0; i < 12; i++) step_check();
        chk("pre_reset_0110", 32'(gray4), 32'h6);

        rst = 1'b1;
        tick();
        check_zero("midreset");
        b4    = 0;
        b3    = 0;
        prev4 = 4'b0000;
        rst   = 1'b0;
        step_check();
        chk("resume_0001", 32'(gray4), 32'h1);
        step_check();
        chk("resume_0011", 32'(gray4), 32'h3);

        // Reset from the terminal code.
        for (int i = 0; i < 13; i++) step_check();
        chk("terminal_gray", 32'(gray4), 32'h8);
        chk("terminal_wrap", 32'(wrap4), 32'd1);
        rst = 1'b1;
        tick();
        check_zero("termreset");
        tick();
        check_zero("hold_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
